vga_timing_controller: RTL and testbench

- Generates VGA 640x480@60 Hz raster timing from the board clock and drives the pixel coordinates (`col`, `row`) that the drawing pipeline consumes.
- Samples the drawer's combinational RGB response and presents registered, blank-masked RGB plus hsync/vsync to the VGA pins.
- Emits a once-per-frame pulse so game logic (Mario position, background updates) changes only during vertical blanking.
- Sits between the top level / pins and the VGA drawer; it is the source end of the `row`/`col` -> RGB interface.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_wrap_counter.sv | 44 ++++
 rtl/vga_timing_controller.sv | 147 ++++++++++++++
 tb/tb_vga_timing_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for the VGA raster generator.
//   - 640x480@60 Hz default timing and the derived line/frame totals
//   - sync polarity constants (syncs are active low)
//   - pixel colour channel width
//   - cnt_width(): register width able to hold modulus-1 (at least 1 bit)
package vga_pkg;

  localparam int CLK_DIV_DEF   = 2;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  localparam int COLOR_W = 4;

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: modulo-MODULUS up counter with enable.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset (count -> 0)
//   en     - advance the count this clk
//   count  - current count, 0..MODULUS-1
//   wrap   - high in the clk where an enabled count moves MODULUS-1 -> 0
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = 800,
  parameter int WIDTH   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;

  always_comb begin
    at_max  = (count_q == WIDTH'(MODULUS - 1));
    count_d = count_q;
    if (en) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & at_max;

endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster timing, pixel coordinates and pin stage.
// Ports:
//   clk, reset                - system clock, synchronous active-high reset
//   red_in/green_in/blue_in   - drawer colour for the current col/row
//   col, row                  - visible pixel coordinate (0 during blanking)
//   pixel_tick                - last clk of each pixel period
//   video_active              - counters are inside the visible area
//   frame_done                - one-clk pulse when the raster enters vertical blanking
//   vga_red/green/blue        - registered, blank-masked pin colour
//   vga_hsync, vga_vsync      - registered active-low syncs, aligned with colour
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [31:0]        col,
  output logic [31:0]        row,
  output logic               pixel_tick,
  output logic               video_active,
  output logic               frame_done,
  output logic [COLOR_W-1:0] vga_red,
  output logic [COLOR_W-1:0] vga_green,
  output logic [COLOR_W-1:0] vga_blue,
  output logic               vga_hsync,
  output logic               vga_vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = cnt_width(CLK_DIV);
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);

  // Pixel-rate divider
  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  always_comb begin
    pixel_tick = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d  = pixel_tick ? '0 : div_cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Raster counters: the line counter steps once per completed line
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap_unused;

  vga_wrap_counter #(.MODULUS(H_TOTAL), .WIDTH(HW)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_tick),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.MODULUS(V_TOTAL), .WIDTH(VW)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap_unused)
  );

  // Raster decode
  logic hsync_raw;
  logic vsync_raw;

  always_comb begin
    video_active = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
    // Blanking coordinates read as 0 so downstream tile lookups stay in range
    col = video_active ? 32'(h_cnt) : 32'd0;
    row = video_active ? 32'(v_cnt) : 32'd0;
    hsync_raw = ((h_cnt >= HW'(H_VISIBLE + H_FRONT)) &&
                 (h_cnt <  HW'(H_VISIBLE + H_FRONT + H_SYNC))) ? SYNC_ACTIVE : SYNC_IDLE;
    vsync_raw = ((v_cnt >= VW'(V_VISIBLE + V_FRONT)) &&
                 (v_cnt <  VW'(V_VISIBLE + V_FRONT + V_SYNC))) ? SYNC_ACTIVE : SYNC_IDLE;
    // The tick that ends the last visible line moves the raster to (0, V_VISIBLE)
    frame_done = h_wrap && (v_cnt == VW'(V_VISIBLE - 1));
  end

  // Pin stage: sampled once per pixel, so pins trail the counters by one pixel
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pixel_tick) begin
      red_d   = video_active ? red_in   : '0;
      green_d = video_active ? green_in : '0;
      blue_d  = video_active ? blue_in  : '0;
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga_red   = red_q;
  assign vga_green = green_q;
  assign vga_blue  = blue_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench with reduced raster geometry so several frames fit in a short run.
// The reference model derives every expectation from the clock count since the last
// reset edge: pixel = n / CLK_DIV, h = pixel mod H_TOTAL, v = (pixel / H_TOTAL) mod V_TOTAL.
module tb_vga_timing_controller;

  localparam int D  = 2;
  localparam int HV = 20, HF = 3, HS = 4, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int N_CYC = 9000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  red_in, green_in, blue_in;
  logic [31:0] col, row;
  logic        pixel_tick, video_active, frame_done;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync;

  always #5 clk = ~clk;

  vga_timing_controller #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .col(col), .row(row), .pixel_tick(pixel_tick), .video_active(video_active),
    .frame_done(frame_done), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  typedef struct {
    int cyc;
    bit tick;
    int col;
    int row;
    bit active;
    bit fd;
    int r, g, b;
    bit hs, vs;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int fd_seen = 0;
  int fd_exp = 0;

  task automatic check(input string name, input int cyc, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every clk
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel_tick",   e.cyc, int'(pixel_tick),   int'(e.tick));
        check("col",          e.cyc, int'(col),          e.col);
        check("row",          e.cyc, int'(row),          e.row);
        check("video_active", e.cyc, int'(video_active), int'(e.active));
        check("frame_done",   e.cyc, int'(frame_done),   int'(e.fd));
        check("vga_red",      e.cyc, int'(vga_red),      e.r);
        check("vga_green",    e.cyc, int'(vga_green),    e.g);
        check("vga_blue",     e.cyc, int'(vga_blue),     e.b);
        check("vga_hsync",    e.cyc, int'(vga_hsync),    int'(e.hs));
        check("vga_vsync",    e.cyc, int'(vga_vsync),    int'(e.vs));
        if (frame_done === 1'b1) fd_seen++;
      end
    end
  end

  // Driver + reference model
  initial begin
    int n;
    int p, h, v;
    bit sampled;
    bit prev_tick, prev_active, prev_hs, prev_vs;
    int pin_r, pin_g, pin_b;
    bit pin_hs, pin_vs;
    bit did_mid;
    int rst_left;
    exp_t e;

    reset = 1'b1;
    red_in = 4'h0; green_in = 4'h0; blue_in = 4'h0;
    n = 0;
    prev_tick = 0; prev_active = 0; prev_hs = 1; prev_vs = 1;
    pin_r = 0; pin_g = 0; pin_b = 0; pin_hs = 1; pin_vs = 1;
    did_mid = 0;
    rst_left = 0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      sampled = reset;
      if (sampled) begin
        n = 0;
        pin_r = 0; pin_g = 0; pin_b = 0; pin_hs = 1; pin_vs = 1;
      end else begin
        n++;
        // red_in etc. still hold the values the DUT sampled at this edge
        if (prev_tick) begin
          pin_r  = prev_active ? int'(red_in)   : 0;
          pin_g  = prev_active ? int'(green_in) : 0;
          pin_b  = prev_active ? int'(blue_in)  : 0;
          pin_hs = prev_hs;
          pin_vs = prev_vs;
        end
      end

      p = n / D;
      h = p % HT;
      v = (p / HT) % VT;
      e.cyc    = cyc;
      e.tick   = ((n % D) == D - 1);
      e.active = (h < HV) && (v < VV);
      e.col    = e.active ? h : 0;
      e.row    = e.active ? v : 0;
      e.fd     = e.tick && (h == HT - 1) && (v == VV - 1);
      e.r = pin_r; e.g = pin_g; e.b = pin_b;
      e.hs = pin_hs; e.vs = pin_vs;
      exp_q.push_back(e);
      if (e.fd) fd_exp++;

      prev_tick   = e.tick;
      prev_active = e.active;
      prev_hs     = !((h >= HV + HF) && (h < HV + HF + HS));
      prev_vs     = !((v >= VV + VF) && (v < VV + VF + VS));

      // Next-clk stimulus
      if (cyc < 4) begin
        reset = 1'b1;
      end else if (!did_mid && cyc > 3000 && h == 13 && v == 7 && !sampled) begin
        reset = 1'b1;
        did_mid = 1;
      end else if (cyc == 7000) begin
        rst_left = $urandom_range(3, 0);
        reset = 1'b1;
      end else if (rst_left > 0) begin
        rst_left--;
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end

      if (cyc < 1500) begin
        red_in = 4'hA; green_in = 4'hA; blue_in = 4'hA;
      end else begin
        red_in   = 4'($urandom);
        green_in = 4'($urandom);
        blue_in  = 4'($urandom);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    check("frame_done_count", N_CYC, fd_seen, fd_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
